// File: rtl/mac_fixed_lanes.sv
// Multi-lane fixed-point multiply / accumulate pipeline with valid/ready handshakes.
// Stage 1 registers exact lane products; stage 2 accumulates, rounds, clamps and presents results.
module mac_fixed_lanes #(
  parameter int LANES = 4,
  parameter int A_W   = 8,
  parameter int B_W   = 8,
  parameter int ACC_W = 20,
  parameter int SHIFT = 8,
  parameter int OUT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*A_W-1:0]   in_a,
  input  logic [LANES*B_W-1:0]   in_b,
  input  logic                   in_acc,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*OUT_W-1:0] out_data,
  output logic [LANES-1:0]       out_sat
);
  // Handshake: a beat moves on any edge where valid && ready; advance = !out_valid || out_ready
  // gates every register, so a stalled output freezes the whole pipeline.
  localparam int P_W = A_W + B_W + 1;
  localparam int X_W = ACC_W + 1;
  localparam logic signed [X_W-1:0] HALF    = X_W'(64'sd1 <<< (SHIFT - 1));
  localparam logic signed [X_W-1:0] OUT_MAX = X_W'((64'sd1 <<< (OUT_W - 1)) - 1);
  localparam logic signed [X_W-1:0] OUT_MIN = -OUT_MAX - X_W'(1);
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic signed [P_W-1:0]   prod_q [LANES];
  logic signed [P_W-1:0]   prod_d [LANES];
  logic signed [ACC_W-1:0] acc_q  [LANES];
  logic signed [ACC_W-1:0] acc_d  [LANES];
  logic                    s1_valid_q, s1_valid_d;
  logic                    s1_acc_q, s1_acc_d;
  logic                    s1_last_q, s1_last_d;
  logic [LANES-1:0]        sticky_q, sticky_d;
  logic                    out_valid_q, out_valid_d;
  logic [LANES*OUT_W-1:0]  out_data_q, out_data_d;
  logic [LANES-1:0]        out_sat_q, out_sat_d;

  logic                    advance, emit, add_sat, clamp;
  logic signed [X_W-1:0]   sum_w, rnd_w, shr_w;
  logic signed [ACC_W-1:0] sum_s;

  always_comb begin
    advance     = !out_valid_q || out_ready;
    emit        = !s1_acc_q || s1_last_q;
    s1_valid_d  = s1_valid_q;
    s1_acc_d    = s1_acc_q;
    s1_last_d   = s1_last_q;
    sticky_d    = sticky_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    add_sat     = 1'b0;
    clamp       = 1'b0;
    sum_w       = '0;
    rnd_w       = '0;
    shr_w       = '0;
    sum_s       = '0;
    for (int i = 0; i < LANES; i++) begin
      prod_d[i] = prod_q[i];
      acc_d[i]  = acc_q[i];
    end
    if (advance) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_acc_d  = in_acc;
        s1_last_d = in_last;
        for (int i = 0; i < LANES; i++)
          prod_d[i] = $signed({1'b0, in_a[i*A_W +: A_W]}) * $signed(in_b[i*B_W +: B_W]);
      end
      out_valid_d = 1'b0;
      if (s1_valid_q) begin
        out_valid_d = emit;
        for (int i = 0; i < LANES; i++) begin
          // A plain beat ignores any partial group, which aborts it.
          sum_w   = X_W'(prod_q[i]) + (s1_acc_q ? X_W'(acc_q[i]) : X_W'(0));
          add_sat = sum_w[X_W-1] ^ sum_w[X_W-2];
          if (add_sat) sum_s = sum_w[X_W-1] ? ACC_MIN : ACC_MAX;
          else         sum_s = sum_w[ACC_W-1:0];
          if (emit) begin
            rnd_w = X_W'(sum_s) + HALF;
            shr_w = rnd_w >>> SHIFT;
            clamp = 1'b0;
            if (shr_w > OUT_MAX) begin
              clamp = 1'b1;
              out_data_d[i*OUT_W +: OUT_W] = OUT_MAX[OUT_W-1:0];
            end else if (shr_w < OUT_MIN) begin
              clamp = 1'b1;
              out_data_d[i*OUT_W +: OUT_W] = OUT_MIN[OUT_W-1:0];
            end else begin
              out_data_d[i*OUT_W +: OUT_W] = shr_w[OUT_W-1:0];
            end
            out_sat_d[i] = clamp | add_sat | (s1_acc_q & sticky_q[i]);
            acc_d[i]     = '0;
            sticky_d[i]  = 1'b0;
          end else begin
            acc_d[i]    = sum_s;
            sticky_d[i] = sticky_q[i] | add_sat;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_acc_q    <= 1'b0;
      s1_last_q   <= 1'b0;
      sticky_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= '0;
      for (int i = 0; i < LANES; i++) begin
        prod_q[i] <= '0;
        acc_q[i]  <= '0;
      end
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_acc_q    <= s1_acc_d;
      s1_last_q   <= s1_last_d;
      sticky_q    <= sticky_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      for (int i = 0; i < LANES; i++) begin
        prod_q[i] <= prod_d[i];
        acc_q[i]  <= acc_d[i];
      end
    end
  end

  assign in_ready  = advance;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
endmodule

// File: tb/tb_mac_fixed_lanes.sv
// Directed and randomized bench for mac_fixed_lanes with an expected-result queue.
module tb_mac_fixed_lanes;
  localparam int LANES = 4, A_W = 8, B_W = 8, ACC_W = 20, SHIFT = 8, OUT_W = 8;
  localparam int R_W = LANES*OUT_W + LANES;
  localparam longint ACC_MAX = (64'sd1 <<< (ACC_W-1)) - 1;
  localparam longint ACC_MIN = -(64'sd1 <<< (ACC_W-1));

  logic clk = 0, rst = 1;
  logic in_valid = 0, in_ready, in_acc = 0, in_last = 0;
  logic [LANES*A_W-1:0] in_a = '0;
  logic [LANES*B_W-1:0] in_b = '0;
  logic out_valid, out_ready = 1;
  logic [LANES*OUT_W-1:0] out_data;
  logic [LANES-1:0] out_sat;

  logic [R_W-1:0] exp_q[$];
  int n_checks = 0, n_errors = 0, stall_seen = 0;
  logic hold_prev = 0;
  logic [R_W-1:0] hold_val;
  logic rand_done;
  longint mdl_acc [LANES];
  logic [LANES-1:0] mdl_sticky;

  mac_fixed_lanes #(.LANES(LANES), .A_W(A_W), .B_W(B_W), .ACC_W(ACC_W), .SHIFT(SHIFT), .OUT_W(OUT_W))
  dut (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
       .in_acc(in_acc), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
       .out_data(out_data), .out_sat(out_sat));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [R_W-1:0] rep(input int val, input logic [LANES-1:0] sat);
    logic [R_W-1:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++) r[i*OUT_W +: OUT_W] = val[OUT_W-1:0];
    r[R_W-1 -: LANES] = sat;
    return r;
  endfunction

  // Reference model in plain integer arithmetic; pushes a result whenever a beat emits.
  task automatic model_beat(input logic [LANES*A_W-1:0] a, input logic [LANES*B_W-1:0] b,
                            input logic acc, input logic last);
    logic [R_W-1:0] r;
    longint p, s, o;
    logic sat;
    r = '0;
    for (int i = 0; i < LANES; i++) begin
      p = longint'(a[i*A_W +: A_W]) * longint'($signed(b[i*B_W +: B_W]));
      s = acc ? mdl_acc[i] + p : p;
      sat = 0;
      if (s > ACC_MAX) begin s = ACC_MAX; sat = 1; end
      if (s < ACC_MIN) begin s = ACC_MIN; sat = 1; end
      if (acc && !last) begin
        mdl_acc[i] = s;
        mdl_sticky[i] = mdl_sticky[i] | sat;
      end else begin
        o = (s + (64'sd1 <<< (SHIFT-1))) >>> SHIFT;
        if (acc && mdl_sticky[i]) sat = 1;
        if (o > 127) begin o = 127; sat = 1; end
        if (o < -128) begin o = -128; sat = 1; end
        r[i*OUT_W +: OUT_W] = o[OUT_W-1:0];
        r[LANES*OUT_W + i] = sat;
        mdl_acc[i] = 0;
        mdl_sticky[i] = 0;
      end
    end
    if (!acc || last) exp_q.push_back(r);
  endtask

  task automatic send_beat(input logic [LANES*A_W-1:0] a, input logic [LANES*B_W-1:0] b,
                           input logic acc, input logic last);
    logic ok;
    in_valid = 1; in_a = a; in_b = b; in_acc = acc; in_last = last;
    ok = 0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) check("accept_timeout", ok, 1);
  endtask

  task automatic idle();
    in_valid = 0; in_acc = 0; in_last = 0;
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(posedge clk);
    #1;
    check("drain_empty", exp_q.size(), 0);
  endtask

  // Output monitor: pops on every transfer, checks hold and in_ready during stalls.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("unexpected_output", out_valid, 0);
      else check("result", {out_sat, out_data}, exp_q.pop_front());
    end
    if (!rst && out_valid && !out_ready) begin
      stall_seen++;
      check("in_ready_stall", in_ready, 0);
      if (hold_prev) check("hold_stable", {out_sat, out_data}, hold_val);
      hold_prev = 1;
      hold_val = {out_sat, out_data};
    end else begin
      hold_prev = 0;
    end
  end

  initial begin
    for (int i = 0; i < LANES; i++) mdl_acc[i] = 0;
    mdl_sticky = '0;
    // Reset with a beat presented that must be ignored
    rst = 1; in_valid = 1; in_a = {4{8'd128}}; in_b = {4{8'd64}};
    repeat (3) @(posedge clk);
    #1 rst = 0; idle();
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_sat", out_sat, 0);
    check("rst_in_ready", in_ready, 1);
    repeat (3) @(negedge clk);
    check("rst_beat_ignored", out_valid, 0);

    // Plain multiply with latency check
    @(posedge clk); #1;
    exp_q.push_back(rep(32, 4'h0));
    send_beat({4{8'd128}}, {4{8'd64}}, 0, 0);
    idle();
    @(negedge clk);
    check("latency_cycle1", out_valid, 0);
    @(negedge clk);
    check("latency_cycle2", out_valid, 1);
    drain();

    // Rounding per lane: 1, 0, 0, -127
    exp_q.push_back({4'h0, 8'h81, 8'h00, 8'h00, 8'h01});
    send_beat({8'd255, 8'd2, 8'd1, 8'd2}, {8'h80, 8'hC0, 8'd127, 8'd64}, 0, 0);
    idle();
    drain();

    // Accumulate group of 4 clamps to 127, then a plain beat
    exp_q.push_back(rep(127, 4'hF));
    for (int k = 0; k < 4; k++) send_beat({4{8'd255}}, {4{8'd127}}, 1, k == 3);
    exp_q.push_back(rep(32, 4'h0));
    send_beat({4{8'd128}}, {4{8'd64}}, 0, 0);
    idle();
    drain();

    // Accumulator saturates high, then comes back into range: sticky flag alone marks it
    exp_q.push_back(rep(8, 4'hF));
    for (int k = 0; k < 17; k++) send_beat({4{8'd255}}, {4{8'd127}}, 1, 0);
    for (int k = 0; k < 16; k++) send_beat({4{8'd255}}, {4{8'h80}}, 1, k == 15);
    idle();
    drain();

    // Plain beat mid-group aborts the group
    send_beat({4{8'd255}}, {4{8'd127}}, 1, 0);
    send_beat({4{8'd255}}, {4{8'd127}}, 1, 0);
    exp_q.push_back(rep(32, 4'h0));
    send_beat({4{8'd128}}, {4{8'd64}}, 0, 0);
    idle();
    drain();

    // Backpressure during a 6-beat stream
    stall_seen = 0;
    for (int k = 0; k < 6; k++) exp_q.push_back(rep(4*(k+1), 4'h0));
    fork
      begin
        for (int k = 0; k < 6; k++) send_beat({4{8'(16*(k+1))}}, {4{8'd64}}, 0, 0);
        idle();
      end
      begin
        repeat (2) @(posedge clk);
        #1 out_ready = 0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1;
      end
    join
    drain();
    check("bp_stall_seen", stall_seen >= 4, 1);

    // Reset in the middle of a group
    send_beat({4{8'd255}}, {4{8'd127}}, 1, 0);
    send_beat({4{8'd255}}, {4{8'd127}}, 1, 0);
    idle();
    rst = 1;
    @(posedge clk); #1 rst = 0;
    exp_q.push_back(rep(32, 4'h0));
    send_beat({4{8'd128}}, {4{8'd64}}, 0, 0);
    idle();
    drain();

    // Random mixed stream with random backpressure
    rand_done = 0;
    fork
      begin
        for (int k = 0; k < 60; k++) begin
          logic [LANES*A_W-1:0] a;
          logic [LANES*B_W-1:0] b;
          logic acc, last;
          a = {$urandom, $urandom} & {(LANES*A_W){1'b1}};
          b = {$urandom, $urandom} & {(LANES*B_W){1'b1}};
          acc = ($urandom_range(0, 2) != 0);
          last = ($urandom_range(0, 2) == 0) || (k == 59);
          model_beat(a, b, acc, last);
          send_beat(a, b, acc, last);
        end
        idle();
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1;
      end
    join
    drain();
    repeat (3) @(negedge clk);
    check("final_idle", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/mac_fixed_lanes.md
MAC_FIXED_LANES -- requirements
Module: mac_fixed_lanes

Interface
REQ-001 SHALL provide parameter LANES, default 4, number of independent multiply lanes.
REQ-002 SHALL provide parameter A_W, default 8, width of unsigned activation per lane.
REQ-003 SHALL provide parameter B_W, default 8, width of signed weight per lane.
REQ-004 SHALL provide parameter ACC_W, default 20, signed accumulator width per lane; ACC_W >= A_W+B_W+1.
REQ-005 SHALL provide parameter SHIFT, default 8, right-shift applied to the accumulator on output; SHIFT >= 1.
REQ-006 SHALL provide parameter OUT_W, default 8, signed output width per lane.
REQ-007 clk  input  1  sole clock; all state on rising edge.
REQ-008 rst  input  1  reset, synchronous and active-high.
REQ-009 in_valid  input  1  input beat valid.
REQ-010 in_ready  output  1  block accepts beat this cycle.
REQ-011 in_a  input  LANES*A_W  unsigned operands, lane i at bits [i*A_W +: A_W].
REQ-012 in_b  input  LANES*B_W  signed operands, lane i at bits [i*B_W +: B_W].
REQ-013 in_acc  input  1  mode: 0 = plain multiply, 1 = accumulate group.
REQ-014 in_last  input  1  final beat of accumulate group; ignored when in_acc=0.
REQ-015 out_valid  output  1  result valid.
REQ-016 out_ready  input  1  downstream accepts result.
REQ-017 out_data  output  LANES*OUT_W  signed results, lane packing as in_a.
REQ-018 out_sat  output  LANES  per-lane saturation flag for the presented result.

Function
REQ-019 advance = !out_valid || out_ready; in_ready SHALL equal advance; beat accepted when in_valid && in_ready.
REQ-020 Stage 1: on accepted beat, each lane SHALL register product = {1'b0,a} * signed b, exact width A_W+B_W+1, plus in_acc/in_last and a stage-1 valid.
REQ-021 Whole pipeline SHALL stall (hold all registers) when advance=0; no beat lost or duplicated.
REQ-022 Stage 2 (stage-1 valid and advance): sum = product sign-extended to ACC_W, plus lane accumulator when in_acc=1.
REQ-023 Accumulator add SHALL saturate to signed ACC_W bounds; a saturation sets a sticky per-lane overflow bit.
REQ-024 in_acc=1, in_last=0: accumulator <= sum; no output produced.
REQ-025 in_acc=0, or in_acc=1 with in_last=1: result emitted, accumulator and sticky bits cleared to 0 the same cycle.
REQ-026 Emit: r = (sum + 2^(SHIFT-1)) >>> SHIFT (round half up, arithmetic shift, computed at ACC_W+1 bits); r saturated to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-027 out_sat[i] SHALL be 1 when lane i output clamped or its sticky overflow bit was set for the group.
REQ-028 Latency: out_valid asserts 2 cycles after acceptance of a emitting beat with no stall; throughput 1 beat/cycle.
REQ-029 out_data/out_sat SHALL hold stable while out_valid && !out_ready.
REQ-030 Plain beat arriving mid-group (in_acc=0 while accumulator nonzero) SHALL use product only and clear the accumulator (group aborted).

Reset
REQ-031 rst=1 SHALL clear stage-1 valid, out_valid, out_data, out_sat, accumulators and sticky bits to 0 on the next edge, discarding in-flight beats and partial groups.
REQ-032 in_ready SHALL be 1 in the cycle after reset deasserts.
REQ-033 Beats presented while rst=1 SHALL be ignored.

Verification
REQ-034 Plain: a=128, b=64 all lanes, in_acc=0, out_ready=1 -> out_data lanes=32, out_sat=0, out_valid 2 cycles later.
REQ-035 Rounding: lane0 a=2,b=64; lane1 a=1,b=127; lane2 a=2,b=-64; lane3 a=255,b=-128 -> 1, 0, 0, -127; out_sat=0.
REQ-036 Accumulate: 4 beats a=255,b=127, in_acc=1, last on beat 4 -> single result 127 per lane, out_sat=1; next plain beat a=128,b=64 -> 32, out_sat=0.
REQ-037 Backpressure: out_ready=0 for 5 cycles during a 6-beat plain stream -> in_ready low while output held, all 6 results delivered in order, unchanged while stalled.
REQ-038 Reset mid-group: 2 accumulate beats, rst pulse, then plain a=128,b=64 -> out=32, no partial-group output.
